// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus bundle for rf_wb_arbiter: two requester channels, registered rf write port,
// and the decode-side scoreboard lock/hazard signals.
interface rf_wb_arbiter_if #(
   parameter int REGNO     = 8,
   parameter int REGNO_LOG = 3,
   parameter int RW        = 16
);
   logic                 i_a_valid;
   logic [REGNO_LOG-1:0] i_a_reg;
   logic [RW-1:0]        i_a_data;
   logic                 o_a_ready;
   logic                 i_b_valid;
   logic [REGNO_LOG-1:0] i_b_reg;
   logic [RW-1:0]        i_b_data;
   logic                 o_b_ready;
   logic [REGNO-1:0]     o_rf_ie;
   logic [RW-1:0]        o_rf_d;
   logic                 i_lock_valid;
   logic [REGNO_LOG-1:0] i_lock_reg;
   logic [REGNO_LOG-1:0] i_lout_sel;
   logic [REGNO_LOG-1:0] i_rout_sel;
   logic [REGNO-1:0]     o_pending;
   logic                 o_hazard;

   modport master (
      output i_a_valid, i_a_reg, i_a_data, i_b_valid, i_b_reg, i_b_data,
             i_lock_valid, i_lock_reg, i_lout_sel, i_rout_sel,
      input  o_a_ready, o_b_ready, o_rf_ie, o_rf_d, o_pending, o_hazard
   );

   modport slave (
      input  i_a_valid, i_a_reg, i_a_data, i_b_valid, i_b_reg, i_b_data,
             i_lock_valid, i_lock_reg, i_lout_sel, i_rout_sel,
      output o_a_ready, o_b_ready, o_rf_ie, o_rf_d, o_pending, o_hazard
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B) results.
// Optional pending-result scoreboard with read-hazard flag, enabled by RF_WB_SCOREBOARD_EN.
module rf_wb_arbiter #(
   parameter int REGNO     = 8,
   parameter int REGNO_LOG = 3,
   parameter int RW        = 16
) (
   input logic            i_clk,
   input logic            i_rst,
   rf_wb_arbiter_if.slave bus
);

   typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} grant_e;

   function automatic logic [REGNO-1:0] onehot(input logic [REGNO_LOG-1:0] idx);
      logic [REGNO-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   grant_e               last_grant_q, last_grant_d;
   logic                 a_gnt, b_gnt, xfer;
   logic [REGNO_LOG-1:0] xfer_reg;
   logic [RW-1:0]        xfer_data;
   logic [REGNO-1:0]     rf_ie_q, rf_ie_d;
   logic [RW-1:0]        rf_d_q, rf_d_d;

   // A wins unless B also wants the port and A was served last.
   always_comb begin
      a_gnt        = bus.i_a_valid & (~bus.i_b_valid | (last_grant_q == GNT_B));
      b_gnt        = bus.i_b_valid & ~a_gnt;
      xfer         = a_gnt | b_gnt;
      xfer_reg     = a_gnt ? bus.i_a_reg  : bus.i_b_reg;
      xfer_data    = a_gnt ? bus.i_a_data : bus.i_b_data;
      last_grant_d = last_grant_q;
      if (a_gnt)      last_grant_d = GNT_A;
      else if (b_gnt) last_grant_d = GNT_B;
      rf_ie_d      = xfer ? onehot(xfer_reg) : '0;
      rf_d_d       = xfer ? xfer_data : rf_d_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         last_grant_q <= GNT_B;
         rf_ie_q      <= '0;
         rf_d_q       <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         rf_ie_q      <= rf_ie_d;
         rf_d_q       <= rf_d_d;
      end
   end

   assign bus.o_a_ready = a_gnt;
   assign bus.o_b_ready = b_gnt;
   assign bus.o_rf_ie   = rf_ie_q;
   assign bus.o_rf_d    = rf_d_q;

`ifdef RF_WB_SCOREBOARD_EN
   logic [REGNO-1:0] pending_q, pending_d;

   // Clear on the commit edge, then OR in a new reservation so a fresh lock wins.
   always_comb begin
      pending_d = pending_q & ~rf_ie_q;
      if (bus.i_lock_valid) pending_d = pending_d | onehot(bus.i_lock_reg);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) pending_q <= '0;
      else       pending_q <= pending_d;
   end

   assign bus.o_pending = pending_q;
   assign bus.o_hazard  = pending_q[bus.i_lout_sel] | pending_q[bus.i_rout_sel];
`else
   logic lock_unused;
   assign lock_unused   = ^{bus.i_lock_valid, bus.i_lock_reg, bus.i_lout_sel, bus.i_rout_sel};
   assign bus.o_pending = '0;
   assign bus.o_hazard  = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_rf_wb_arbiter;
   localparam int REGNO = 8;
   localparam int REGNO_LOG = 3;
   localparam int RW = 16;

   logic clk;
   logic rst;
   int   checks;
   int   passes;

   rf_wb_arbiter_if #(.REGNO(REGNO), .REGNO_LOG(REGNO_LOG), .RW(RW)) bus ();

   rf_wb_arbiter #(.REGNO(REGNO), .REGNO_LOG(REGNO_LOG), .RW(RW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: who was served most recently, the write in flight, rf contents, outstanding set.
   bit          m_last_b;
   bit          m_wr_vld;
   int          m_wr_idx;
   logic [15:0] m_wr_data;
   bit          m_pend [REGNO];
   logic [15:0] m_rf   [REGNO];
   logic [15:0] dut_rf [REGNO];

   function automatic bit want_a();
      return bus.i_a_valid && (!bus.i_b_valid || m_last_b);
   endfunction

   function automatic bit want_b();
      return bus.i_b_valid && !want_a();
   endfunction

   function automatic logic [7:0] exp_ie();
      return m_wr_vld ? (8'b1 << m_wr_idx) : 8'b0;
   endfunction

   function automatic logic [7:0] exp_pend();
      logic [7:0] v;
      for (int i = 0; i < REGNO; i++) v[i] = m_pend[i];
      return v;
   endfunction

   function automatic bit exp_hazard();
      return m_pend[bus.i_lout_sel] || m_pend[bus.i_rout_sel];
   endfunction

   task automatic model_reset();
      m_last_b  = 1'b1;
      m_wr_vld  = 1'b0;
      m_wr_data = 16'h0;
      for (int i = 0; i < REGNO; i++) m_pend[i] = 1'b0;
   endtask

   task automatic drive(input bit av, input logic [2:0] ar, input logic [15:0] ad,
                        input bit bv, input logic [2:0] br, input logic [15:0] bd,
                        input bit lv, input logic [2:0] lr,
                        input logic [2:0] ls, input logic [2:0] rs);
      @(negedge clk);
      bus.i_a_valid = av; bus.i_a_reg = ar; bus.i_a_data = ad;
      bus.i_b_valid = bv; bus.i_b_reg = br; bus.i_b_data = bd;
      bus.i_lock_valid = lv; bus.i_lock_reg = lr;
      bus.i_lout_sel = ls; bus.i_rout_sel = rs;
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 0, 0);
   endtask

   task automatic clk_edge();
      logic [7:0]  s_ie;
      logic [15:0] s_d;
      bit          ga, gb;
      s_ie = bus.o_rf_ie;
      s_d  = bus.o_rf_d;
      ga   = want_a();
      gb   = want_b();
      @(posedge clk);
      for (int i = 0; i < REGNO; i++) if (s_ie[i]) dut_rf[i] = s_d;
      if (m_wr_vld) begin
         m_rf[m_wr_idx]   = m_wr_data;
         m_pend[m_wr_idx] = 1'b0;
      end
`ifdef RF_WB_SCOREBOARD_EN
      if (bus.i_lock_valid) m_pend[bus.i_lock_reg] = 1'b1;
`endif
      if (ga) begin
         m_wr_vld = 1; m_wr_idx = int'(bus.i_a_reg); m_wr_data = bus.i_a_data; m_last_b = 0;
      end else if (gb) begin
         m_wr_vld = 1; m_wr_idx = int'(bus.i_b_reg); m_wr_data = bus.i_b_data; m_last_b = 1;
      end else begin
         m_wr_vld = 0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.i_a_valid = 0; bus.i_b_valid = 0; bus.i_lock_valid = 0;
      #2;
      model_reset();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      checks++; if (bus.o_rf_ie !== 8'h00) $display("FAIL reset_ie got=%h want=00", bus.o_rf_ie); else passes++;
      checks++; if (bus.o_rf_d !== 16'h0) $display("FAIL reset_d got=%h want=0000", bus.o_rf_d); else passes++;
      checks++; if (bus.o_pending !== 8'h00) $display("FAIL reset_pending got=%h want=00", bus.o_pending); else passes++;
      checks++; if ({bus.o_a_ready, bus.o_b_ready} !== 2'b00) $display("FAIL reset_ready got=%b want=00", {bus.o_a_ready, bus.o_b_ready}); else passes++;
      checks++; if (bus.o_hazard !== 1'b0) $display("FAIL reset_hazard got=%b want=0", bus.o_hazard); else passes++;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_a_only();
      drive(1, 3, 16'h1234, 0, 0, 16'h0, 0, 0, 0, 0);
      checks++; if ({bus.o_a_ready, bus.o_b_ready} !== 2'b10) $display("FAIL aonly_ready got=%b want=10", {bus.o_a_ready, bus.o_b_ready}); else passes++;
      clk_edge();
      idle();
      checks++; if (bus.o_rf_ie !== 8'b0000_1000) $display("FAIL aonly_ie got=%b want=00001000", bus.o_rf_ie); else passes++;
      checks++; if (bus.o_rf_d !== 16'h1234) $display("FAIL aonly_d got=%h want=1234", bus.o_rf_d); else passes++;
      clk_edge();
      idle();
      checks++; if (bus.o_rf_ie !== 8'h00) $display("FAIL aonly_ie_off got=%b want=0", bus.o_rf_ie); else passes++;
      checks++; if (bus.o_rf_d !== 16'h1234) $display("FAIL aonly_d_hold got=%h want=1234", bus.o_rf_d); else passes++;
      clk_edge();
   endtask

   task automatic test_contention();
      logic [7:0] ie_tab [5];
      ie_tab[0] = 8'h00; ie_tab[1] = 8'h02; ie_tab[2] = 8'h10; ie_tab[3] = 8'h02; ie_tab[4] = 8'h10;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive(1, 1, 16'hA000 + 16'(k), 1, 4, 16'hB000 + 16'(k), 0, 0, 0, 0);
         checks++; if (bus.o_a_ready !== ((k % 2) == 0)) $display("FAIL cont_a_ready k=%0d got=%b want=%b", k, bus.o_a_ready, (k % 2) == 0); else passes++;
         checks++; if (bus.o_b_ready !== ((k % 2) == 1)) $display("FAIL cont_b_ready k=%0d got=%b want=%b", k, bus.o_b_ready, (k % 2) == 1); else passes++;
         checks++; if (bus.o_rf_ie !== ie_tab[k]) $display("FAIL cont_ie k=%0d got=%h want=%h", k, bus.o_rf_ie, ie_tab[k]); else passes++;
         clk_edge();
      end
      idle();
      checks++; if (bus.o_rf_ie !== ie_tab[4]) $display("FAIL cont_ie_last got=%h want=%h", bus.o_rf_ie, ie_tab[4]); else passes++;
      checks++; if (bus.o_rf_d !== 16'hB003) $display("FAIL cont_d_last got=%h want=b003", bus.o_rf_d); else passes++;
      clk_edge();
   endtask

   task automatic test_same_reg();
      do_reset();
      drive(1, 0, 16'h0001, 0, 0, 16'h0, 0, 0, 0, 0);
      clk_edge();
      drive(1, 5, 16'hAAAA, 1, 5, 16'hBBBB, 0, 0, 0, 0);
      checks++; if ({bus.o_a_ready, bus.o_b_ready} !== 2'b01) $display("FAIL same_first got=%b want=01", {bus.o_a_ready, bus.o_b_ready}); else passes++;
      clk_edge();
      drive(1, 5, 16'hAAAA, 0, 0, 16'h0, 0, 0, 0, 0);
      checks++; if (bus.o_a_ready !== 1'b1) $display("FAIL same_second got=%b want=1", bus.o_a_ready); else passes++;
      checks++; if (bus.o_rf_d !== 16'hBBBB) $display("FAIL same_d1 got=%h want=bbbb", bus.o_rf_d); else passes++;
      clk_edge();
      idle();
      checks++; if (bus.o_rf_ie !== 8'h20 || bus.o_rf_d !== 16'hAAAA) $display("FAIL same_d2 got=%h/%h want=20/aaaa", bus.o_rf_ie, bus.o_rf_d); else passes++;
      clk_edge();
      idle();
      clk_edge();
      checks++; if (dut_rf[5] !== 16'hAAAA) $display("FAIL same_final got=%h want=aaaa", dut_rf[5]); else passes++;
   endtask

   task automatic test_scoreboard();
      do_reset();
`ifdef RF_WB_SCOREBOARD_EN
      drive(0, 0, 16'h0, 0, 0, 16'h0, 1, 2, 0, 0);
      checks++; if (bus.o_pending !== 8'h00) $display("FAIL sb_pre got=%h want=00", bus.o_pending); else passes++;
      clk_edge();
      drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 2, 7);
      checks++; if (bus.o_pending !== 8'h04) $display("FAIL sb_lock got=%h want=04", bus.o_pending); else passes++;
      checks++; if (bus.o_hazard !== 1'b1) $display("FAIL sb_hazard got=%b want=1", bus.o_hazard); else passes++;
      clk_edge();
      drive(0, 0, 16'h0, 1, 2, 16'hCAFE, 0, 0, 7, 7);
      checks++; if (bus.o_hazard !== 1'b0) $display("FAIL sb_nohazard got=%b want=0", bus.o_hazard); else passes++;
      clk_edge();
      drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 2, 2);
      checks++; if (bus.o_rf_ie !== 8'h04 || bus.o_pending !== 8'h04) $display("FAIL sb_precommit got=%h/%h want=04/04", bus.o_rf_ie, bus.o_pending); else passes++;
      clk_edge();
      drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 2, 2);
      checks++; if (bus.o_pending !== 8'h00 || bus.o_hazard !== 1'b0) $display("FAIL sb_commit got=%h/%b want=00/0", bus.o_pending, bus.o_hazard); else passes++;
      clk_edge();
      drive(0, 0, 16'h0, 0, 0, 16'h0, 1, 2, 0, 0);
      clk_edge();
      drive(0, 0, 16'h0, 1, 2, 16'hD00D, 0, 0, 0, 0);
      clk_edge();
      drive(0, 0, 16'h0, 0, 0, 16'h0, 1, 2, 0, 0);
      checks++; if (bus.o_rf_ie !== 8'h04) $display("FAIL sb_relock_ie got=%h want=04", bus.o_rf_ie); else passes++;
      clk_edge();
      idle();
      checks++; if (bus.o_pending !== 8'h04) $display("FAIL sb_relock got=%h want=04", bus.o_pending); else passes++;
      clk_edge();
`else
      drive(0, 0, 16'h0, 0, 0, 16'h0, 1, 1, 1, 1);
      clk_edge();
      drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 1, 1);
      checks++; if (bus.o_pending !== 8'h00) $display("FAIL sb_off_pending got=%h want=00", bus.o_pending); else passes++;
      checks++; if (bus.o_hazard !== 1'b0) $display("FAIL sb_off_hazard got=%b want=0", bus.o_hazard); else passes++;
      clk_edge();
`endif
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(1, 3, 16'h5555, 0, 0, 16'h0, 1, 6, 0, 0);
      clk_edge();
      idle();
      checks++; if (bus.o_rf_ie !== 8'h08) $display("FAIL arst_pre_ie got=%h want=08", bus.o_rf_ie); else passes++;
      #1 rst = 1'b1;
      #1;
      checks++; if (bus.o_rf_ie !== 8'h00) $display("FAIL arst_ie got=%h want=00", bus.o_rf_ie); else passes++;
      checks++; if (bus.o_rf_d !== 16'h0) $display("FAIL arst_d got=%h want=0000", bus.o_rf_d); else passes++;
      checks++; if (bus.o_pending !== 8'h00) $display("FAIL arst_pending got=%h want=00", bus.o_pending); else passes++;
      model_reset();
      #1 rst = 1'b0;
      clk_edge();
      drive(1, 0, 16'h0101, 1, 7, 16'h0707, 0, 0, 0, 0);
      checks++; if ({bus.o_a_ready, bus.o_b_ready} !== 2'b10) $display("FAIL arst_arb got=%b want=10", {bus.o_a_ready, bus.o_b_ready}); else passes++;
      clk_edge();
      idle();
      clk_edge();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
               1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
         checks++; if (bus.o_a_ready !== want_a()) $display("FAIL rnd_a_ready n=%0d got=%b want=%b", n, bus.o_a_ready, want_a()); else passes++;
         checks++; if (bus.o_b_ready !== want_b()) $display("FAIL rnd_b_ready n=%0d got=%b want=%b", n, bus.o_b_ready, want_b()); else passes++;
         checks++; if (bus.o_rf_ie !== exp_ie()) $display("FAIL rnd_ie n=%0d got=%h want=%h", n, bus.o_rf_ie, exp_ie()); else passes++;
         checks++; if (bus.o_rf_d !== m_wr_data) $display("FAIL rnd_d n=%0d got=%h want=%h", n, bus.o_rf_d, m_wr_data); else passes++;
         checks++; if (bus.o_pending !== exp_pend()) $display("FAIL rnd_pending n=%0d got=%h want=%h", n, bus.o_pending, exp_pend()); else passes++;
         checks++; if (bus.o_hazard !== exp_hazard()) $display("FAIL rnd_hazard n=%0d got=%b want=%b", n, bus.o_hazard, exp_hazard()); else passes++;
         clk_edge();
      end
      idle();
      clk_edge();
      idle();
      clk_edge();
      for (int i = 0; i < REGNO; i++) begin
         checks++; if (dut_rf[i] !== m_rf[i]) $display("FAIL rnd_rf r%0d got=%h want=%h", i, dut_rf[i], m_rf[i]); else passes++;
      end
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      checks = 0;
      passes = 0;
      bus.i_a_valid = 0; bus.i_a_reg = 0; bus.i_a_data = 0;
      bus.i_b_valid = 0; bus.i_b_reg = 0; bus.i_b_data = 0;
      bus.i_lock_valid = 0; bus.i_lock_reg = 0;
      bus.i_lout_sel = 0; bus.i_rout_sel = 0;
      for (int i = 0; i < REGNO; i++) begin
         m_rf[i]   = 16'h0;
         dut_rf[i] = 16'h0;
      end
      model_reset();
      test_reset();
      test_a_only();
      test_contention();
      test_same_reg();
      test_scoreboard();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
